// File: rtl/cache_port_arbiter_if.sv
// rtl/cache_port_arbiter_if.sv - bundle of requester and cache signals for cache_port_arbiter
//
// Purpose: carries the I-port (fetch) and D-port (load/store) requester signals
// and the shared cache request interface as one bus.
// Modports:
//   slave  - arbiter side: takes requests and cache responses, drives DOUT/RDY,
//            the C_* request registers and GNT_D.
//   master - environment side: drives requests and cache responses.
interface cache_port_arbiter_if;
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic [31:0] I_DOUT;
  logic        I_RDY;

  logic        D_REQ;
  logic        D_WE;
  logic [31:0] D_ADDR;
  logic [31:0] D_DIN;
  logic [2:0]  D_LIM;
  logic        D_SIGNED;
  logic [31:0] D_DOUT;
  logic        D_RDY;

  logic [31:0] C_ADDR;
  logic [31:0] C_DIN;
  logic        C_WE;
  logic        C_RREQ;
  logic [2:0]  C_LIM;
  logic        C_SIGNED;
  logic [31:0] C_DOUT;
  logic        C_RDY;

  logic        GNT_D;

  modport slave (
    input  I_REQ, I_ADDR,
    output I_DOUT, I_RDY,
    input  D_REQ, D_WE, D_ADDR, D_DIN, D_LIM, D_SIGNED,
    output D_DOUT, D_RDY,
    output C_ADDR, C_DIN, C_WE, C_RREQ, C_LIM, C_SIGNED,
    input  C_DOUT, C_RDY,
    output GNT_D
  );

  modport master (
    output I_REQ, I_ADDR,
    input  I_DOUT, I_RDY,
    output D_REQ, D_WE, D_ADDR, D_DIN, D_LIM, D_SIGNED,
    input  D_DOUT, D_RDY,
    input  C_ADDR, C_DIN, C_WE, C_RREQ, C_LIM, C_SIGNED,
    output C_DOUT, C_RDY,
    input  GNT_D
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - two-port arbiter/sequencer in front of the cache
//
// Purpose: shares one cache request interface between the instruction-fetch
// port (read-only, word) and the load/store port. One transaction in flight:
// IDLE (arbitrate + latch) -> ISSUE (one-cycle C_WE/C_RREQ) -> WAIT (for C_RDY)
// -> RESP (one-cycle I_RDY/D_RDY) -> IDLE.
// Ports:
//   CLK  - clock, all state on rising edge
//   RST  - asynchronous active-high reset, aborts any transaction
//   bus  - cache_port_arbiter_if.slave: I-port, D-port, cache side and GNT_D
// Parameter:
//   I_FIRST - 1: first simultaneous request after reset goes to the I-port
// Configuration macro:
//   ARB_FIXED_PRIO_EN - when defined, the D-port always wins simultaneous
//                       requests; otherwise round-robin on ties.
module cache_port_arbiter #(
  parameter bit I_FIRST = 1'b1
) (
  input logic                  CLK,
  input logic                  RST,
  cache_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] c_addr_q, c_addr_d;
  logic [31:0] c_din_q, c_din_d;
  logic        c_we_q, c_we_d;
  logic        c_rreq_q, c_rreq_d;
  logic [2:0]  c_lim_q, c_lim_d;
  logic        c_signed_q, c_signed_d;
  logic        op_we_q, op_we_d;
  logic        gnt_d_q, gnt_d_d;
  logic [31:0] i_dout_q, i_dout_d;
  logic [31:0] d_dout_q, d_dout_d;
  logic        i_rdy_q, i_rdy_d;
  logic        d_rdy_q, d_rdy_d;
  logic        take_d;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    take_d = bus.D_REQ;
  end
`else
  // pri_i_q: the I-port wins the next tie (i.e. the D-port was granted last).
  logic pri_i_q, pri_i_d;

  always_comb begin
    take_d = bus.D_REQ && (!bus.I_REQ || !pri_i_q);
  end

  always_comb begin
    pri_i_d = pri_i_q;
    if (state_q == IDLE && (bus.I_REQ || bus.D_REQ)) begin
      pri_i_d = take_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pri_i_q <= I_FIRST;
    end else begin
      pri_i_q <= pri_i_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    c_addr_d   = c_addr_q;
    c_din_d    = c_din_q;
    c_lim_d    = c_lim_q;
    c_signed_d = c_signed_q;
    op_we_d    = op_we_q;
    gnt_d_d    = gnt_d_q;
    i_dout_d   = i_dout_q;
    d_dout_d   = d_dout_q;
    c_we_d     = 1'b0;
    c_rreq_d   = 1'b0;
    i_rdy_d    = 1'b0;
    d_rdy_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.I_REQ || bus.D_REQ) begin
          state_d = ISSUE;
          gnt_d_d = take_d;
          if (take_d) begin
            c_addr_d   = bus.D_ADDR;
            c_din_d    = bus.D_DIN;
            c_lim_d    = bus.D_LIM;
            c_signed_d = bus.D_SIGNED;
            op_we_d    = bus.D_WE;
          end else begin
            c_addr_d   = bus.I_ADDR;
            c_din_d    = 32'd0;
            c_lim_d    = 3'd3;
            c_signed_d = 1'b0;
            op_we_d    = 1'b0;
          end
          // Strobes are registered so they are high exactly while in ISSUE.
          c_we_d   = op_we_d;
          c_rreq_d = !op_we_d;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.C_RDY) begin
          state_d = RESP;
          if (!op_we_q) begin
            if (gnt_d_q) begin
              d_dout_d = bus.C_DOUT;
            end else begin
              i_dout_d = bus.C_DOUT;
            end
          end
          i_rdy_d = !gnt_d_q;
          d_rdy_d = gnt_d_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      c_addr_q   <= 32'd0;
      c_din_q    <= 32'd0;
      c_we_q     <= 1'b0;
      c_rreq_q   <= 1'b0;
      c_lim_q    <= 3'd0;
      c_signed_q <= 1'b0;
      op_we_q    <= 1'b0;
      gnt_d_q    <= ~I_FIRST;
      i_dout_q   <= 32'd0;
      d_dout_q   <= 32'd0;
      i_rdy_q    <= 1'b0;
      d_rdy_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_addr_q   <= c_addr_d;
      c_din_q    <= c_din_d;
      c_we_q     <= c_we_d;
      c_rreq_q   <= c_rreq_d;
      c_lim_q    <= c_lim_d;
      c_signed_q <= c_signed_d;
      op_we_q    <= op_we_d;
      gnt_d_q    <= gnt_d_d;
      i_dout_q   <= i_dout_d;
      d_dout_q   <= d_dout_d;
      i_rdy_q    <= i_rdy_d;
      d_rdy_q    <= d_rdy_d;
    end
  end

  assign bus.C_ADDR   = c_addr_q;
  assign bus.C_DIN    = c_din_q;
  assign bus.C_WE     = c_we_q;
  assign bus.C_RREQ   = c_rreq_q;
  assign bus.C_LIM    = c_lim_q;
  assign bus.C_SIGNED = c_signed_q;
  assign bus.I_DOUT   = i_dout_q;
  assign bus.I_RDY    = i_rdy_q;
  assign bus.D_DOUT   = d_dout_q;
  assign bus.D_RDY    = d_rdy_q;
  assign bus.GNT_D    = gnt_d_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - self-checking bench for cache_port_arbiter
module tb_cache_port_arbiter;
  localparam bit I_FIRST = 1'b1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  cache_port_arbiter_if bus ();
  cache_port_arbiter #(.I_FIRST(I_FIRST)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Cache responder: C_RDY pulse 'lat' cycles after the strobe cycle.
  int          lat = 1;
  logic [31:0] rdata = 32'h0;
  int          spur_req = 0;
  int          spur_ack = 0;
  int          rcnt = 0;
  initial begin
    bus.C_RDY  = 1'b0;
    bus.C_DOUT = 32'h0;
    forever begin
      @(posedge CLK);
      #2;
      bus.C_RDY  = 1'b0;
      bus.C_DOUT = 32'hBAD0BAD0;
      if (spur_req != spur_ack) begin
        spur_ack   = spur_req;
        bus.C_RDY  = 1'b1;
        bus.C_DOUT = 32'h5A5A5A5A;
      end else if (bus.C_RREQ || bus.C_WE) begin
        rcnt = lat;
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          bus.C_RDY  = 1'b1;
          bus.C_DOUT = rdata;
        end
      end
    end
  end

  // Behavioural model: a transaction is granted, its strobe appears one cycle
  // later, it waits for C_RDY, then the owner sees one RDY cycle.
  bit          m_busy, m_resp, m_own_d, m_we, m_signed, m_gnt, m_i_rdy, m_d_rdy;
  int          m_age, m_last;
  logic [31:0] m_addr, m_din, m_i_dout, m_d_dout;
  logic [2:0]  m_lim;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_busy = 0; m_resp = 0; m_age = 0; m_last = -1;
      m_addr = 0; m_din = 0; m_we = 0; m_lim = 0; m_signed = 0;
      m_i_dout = 0; m_d_dout = 0; m_i_rdy = 0; m_d_rdy = 0;
      m_gnt = ~I_FIRST; m_own_d = 0;
    end else begin
      m_i_rdy = 0;
      m_d_rdy = 0;
      if (!m_busy) begin
        if (bus.I_REQ || bus.D_REQ) begin
          if (bus.I_REQ && bus.D_REQ) begin
`ifdef ARB_FIXED_PRIO_EN
            m_own_d = 1;
`else
            if (m_last < 0) m_own_d = !I_FIRST;
            else m_own_d = (m_last == 0);
`endif
          end else begin
            m_own_d = bus.D_REQ;
          end
          m_last = m_own_d ? 1 : 0;
          m_gnt  = m_own_d;
          if (m_own_d) begin
            m_addr = bus.D_ADDR; m_din = bus.D_DIN; m_we = bus.D_WE;
            m_lim = bus.D_LIM; m_signed = bus.D_SIGNED;
          end else begin
            m_addr = bus.I_ADDR; m_din = 0; m_we = 0; m_lim = 3; m_signed = 0;
          end
          m_busy = 1;
          m_age  = 1;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_resp) begin
        m_busy = 0;
        m_resp = 0;
      end else if (bus.C_RDY) begin
        m_resp = 1;
        if (!m_we) begin
          if (m_own_d) m_d_dout = bus.C_DOUT;
          else m_i_dout = bus.C_DOUT;
        end
        if (m_own_d) m_d_rdy = 1;
        else m_i_rdy = 1;
      end
    end
  end

  // Single compare process against the model, every cycle.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("C_ADDR", bus.C_ADDR, m_addr);
      chk("C_DIN", bus.C_DIN, m_din);
      chk("C_WE", {31'd0, bus.C_WE}, {31'd0, m_busy && m_age == 1 && m_we});
      chk("C_RREQ", {31'd0, bus.C_RREQ}, {31'd0, m_busy && m_age == 1 && !m_we});
      chk("C_LIM", {29'd0, bus.C_LIM}, {29'd0, m_lim});
      chk("C_SIGNED", {31'd0, bus.C_SIGNED}, {31'd0, m_signed});
      chk("I_DOUT", bus.I_DOUT, m_i_dout);
      chk("D_DOUT", bus.D_DOUT, m_d_dout);
      chk("I_RDY", {31'd0, bus.I_RDY}, {31'd0, m_i_rdy});
      chk("D_RDY", {31'd0, bus.D_RDY}, {31'd0, m_d_rdy});
      chk("GNT_D", {31'd0, bus.GNT_D}, {31'd0, m_gnt});
    end
  end

  // Pulse monitor for the directed literal checks.
  int cnt_irdy = 0, cnt_drdy = 0, cnt_rreq = 0, cnt_we = 0, irdy_cyc = 0;
  int order[$];
  always @(negedge CLK) begin
    if (bus.I_RDY === 1'b1) begin cnt_irdy++; irdy_cyc = cyc; order.push_back(0); end
    if (bus.D_RDY === 1'b1) begin cnt_drdy++; order.push_back(1); end
    if (bus.C_RREQ === 1'b1) cnt_rreq++;
    if (bus.C_WE === 1'b1) cnt_we++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_pulse(input bit d_port, input int maxc, input string nm);
    int k = 0;
    bit seen = 0;
    while (!seen && k < maxc) begin
      @(negedge CLK);
      seen = d_port ? (bus.D_RDY === 1'b1) : (bus.I_RDY === 1'b1);
      k++;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: no RDY within %0d cycles", nm, maxc);
    end
  endtask

  int n0, b_i, b_d, b_r, b_w, b_o;
  int exp_order[4];

  task automatic snap();
    b_i = cnt_irdy; b_d = cnt_drdy; b_r = cnt_rreq; b_w = cnt_we; b_o = order.size();
  endtask

  initial begin
    RST = 1'b1;
    bus.I_REQ = 0; bus.I_ADDR = 0;
    bus.D_REQ = 0; bus.D_WE = 0; bus.D_ADDR = 0; bus.D_DIN = 0; bus.D_LIM = 0; bus.D_SIGNED = 0;
    repeat (3) tick();
    chk_en = 1;
    chk("rst C_ADDR", bus.C_ADDR, 32'h0);
    chk("rst C_RREQ", {31'd0, bus.C_RREQ}, 32'h0);
    chk("rst I_DOUT", bus.I_DOUT, 32'h0);
    chk("rst GNT_D", {31'd0, bus.GNT_D}, 32'h0);
    RST = 1'b0;
    tick();

    // Single fetch, C_RDY at N+5.
    snap(); lat = 4; rdata = 32'hDEADBEEF;
    bus.I_ADDR = 32'h100; bus.I_REQ = 1; n0 = cyc;
    @(negedge CLK); @(negedge CLK);
    chk("fetch C_RREQ", {31'd0, bus.C_RREQ}, 32'h1);
    chk("fetch C_ADDR", bus.C_ADDR, 32'h100);
    chk("fetch C_LIM", {29'd0, bus.C_LIM}, 32'h3);
    wait_pulse(0, 20, "fetch");
    tick(); bus.I_REQ = 0;
    chk("fetch I_DOUT", bus.I_DOUT, 32'hDEADBEEF);
    chk("fetch rdy cycle", irdy_cyc, n0 + 6);
    chk("fetch rreq count", cnt_rreq - b_r, 1);
    chk("fetch D_RDY count", cnt_drdy - b_d, 0);
    tick();

    // Store byte.
    snap(); lat = 2; rdata = 32'h12345678;
    bus.D_WE = 1; bus.D_ADDR = 32'h20; bus.D_DIN = 32'hA5; bus.D_LIM = 0; bus.D_REQ = 1;
    @(negedge CLK); @(negedge CLK);
    chk("store C_WE", {31'd0, bus.C_WE}, 32'h1);
    chk("store C_DIN", bus.C_DIN, 32'hA5);
    chk("store C_LIM", {29'd0, bus.C_LIM}, 32'h0);
    wait_pulse(1, 20, "store");
    tick(); bus.D_REQ = 0;
    chk("store C_WE count", cnt_we - b_w, 1);
    chk("store C_RREQ count", cnt_rreq - b_r, 0);
    chk("store D_DOUT", bus.D_DOUT, 32'h0);
    tick();

    // Signed halfword load.
    snap(); lat = 3; rdata = 32'hFFFF8000;
    bus.D_WE = 0; bus.D_ADDR = 32'h42; bus.D_LIM = 1; bus.D_SIGNED = 1; bus.D_REQ = 1;
    @(negedge CLK); @(negedge CLK);
    chk("lh C_LIM", {29'd0, bus.C_LIM}, 32'h1);
    chk("lh C_SIGNED", {31'd0, bus.C_SIGNED}, 32'h1);
    wait_pulse(1, 20, "lh");
    tick(); bus.D_REQ = 0; bus.D_SIGNED = 0;
    chk("lh D_DOUT", bus.D_DOUT, 32'hFFFF8000);
    chk("lh I_DOUT kept", bus.I_DOUT, 32'hDEADBEEF);

    // Spurious C_RDY in IDLE, then D_ADDR changed during WAIT.
    snap(); spur_req++;
    repeat (3) tick();
    chk("spur RDY count", (cnt_irdy - b_i) + (cnt_drdy - b_d), 0);
    lat = 5; rdata = 32'h0BADF00D;
    bus.D_ADDR = 32'h300; bus.D_LIM = 3; bus.D_REQ = 1;
    tick(); tick(); tick();
    bus.D_ADDR = 32'h999; bus.D_LIM = 0;
    @(negedge CLK);
    chk("wait C_ADDR held", bus.C_ADDR, 32'h300);
    wait_pulse(1, 20, "ld after change");
    tick(); bus.D_REQ = 0;
    chk("ld D_DOUT", bus.D_DOUT, 32'h0BADF00D);
    tick();

    // Reset in WAIT aborts; the late C_RDY is ignored.
    snap(); lat = 6; rdata = 32'h11111111;
    bus.I_ADDR = 32'h400; bus.I_REQ = 1;
    tick(); tick(); tick();
    RST = 1; bus.I_REQ = 0;
    #1;
    chk("abort C_ADDR", bus.C_ADDR, 32'h0);
    chk("abort I_DOUT", bus.I_DOUT, 32'h0);
    chk("abort D_DOUT", bus.D_DOUT, 32'h0);
    tick(); RST = 0;
    repeat (10) tick();
    chk("abort RDY count", (cnt_irdy - b_i) + (cnt_drdy - b_d), 0);
    lat = 1; rdata = 32'hCAFE0001;
    bus.I_ADDR = 32'h500; bus.I_REQ = 1; n0 = cyc;
    wait_pulse(0, 20, "post-reset fetch");
    tick(); bus.I_REQ = 0;
    chk("post-reset I_DOUT", bus.I_DOUT, 32'hCAFE0001);
    chk("min latency", irdy_cyc, n0 + 3);

    // Tie after reset, both requests held for four transactions.
    tick(); RST = 1; tick(); RST = 0; tick();
    snap(); lat = 1; rdata = 32'h77;
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{1, 1, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    bus.I_ADDR = 32'h600; bus.D_ADDR = 32'h700; bus.D_WE = 0; bus.D_LIM = 3;
    bus.I_REQ = 1; bus.D_REQ = 1;
    for (int k = 0; k < 60 && order.size() < b_o + 4; k++) @(negedge CLK);
    tick(); bus.I_REQ = 0; bus.D_REQ = 0;
    chk("tie txn count", order.size() - b_o, 4);
    for (int k = 0; k < 4; k++) begin
      if (order.size() > b_o + k) chk($sformatf("tie order %0d", k), order[b_o + k], exp_order[k]);
    end
`ifdef ARB_FIXED_PRIO_EN
    chk("fixed I_RDY count", cnt_irdy - b_i, 0);
`endif
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-port arbiter and sequencer in front of the cache top level of the RISC-V core. It shares the single cache request interface (address, data, write enable, read request, access width, sign extension, data out, ready) between the instruction-fetch port (read-only, word) and the load/store port (read/write, byte/half/word). It sequences one outstanding transaction at a time: latch, issue, wait for the cache ready pulse, return data and a one-cycle ready to the owning requester.

## Interface
Parameters:
- I_FIRST, 1, which port wins the first simultaneous request after reset in round-robin mode (1 = I-port, 0 = D-port).

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous active-high reset
- I_REQ  in  1  fetch request, level, held until I_RDY
- I_ADDR  in  32  fetch address
- I_DOUT  out  32  fetched word, registered
- I_RDY  out  1  one-cycle completion pulse for I-port
- D_REQ  in  1  load/store request, level, held until D_RDY
- D_WE  in  1  1 = store, 0 = load
- D_ADDR  in  32  load/store address
- D_DIN  in  32  store data
- D_LIM  in  3  width: 0 byte, 1 half, 3 word
- D_SIGNED  in  1  sign-extend load
- D_DOUT  out  32  load data, registered
- D_RDY  out  1  one-cycle completion pulse for D-port
- C_ADDR, C_DIN  out  32  to cache
- C_WE, C_RREQ  out  1  to cache, one-cycle strobes
- C_LIM  out  3, C_SIGNED  out  1  to cache
- C_DOUT  in  32  cache read data
- C_RDY  in  1  cache completion, single-cycle pulse
- GNT_D  out  1  current/last owner (1 = D-port), debug

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any REQ is high, select owner, latch its ADDR/DIN/WE/LIM/SIGNED into C_* registers, go to ISSUE. I-port latches LIM = 3, SIGNED = 0, WE = 0, DIN = 0.
- Arbitration (round-robin): only one requester wins. On a tie, the port not granted last wins; the first tie after reset goes to I-port if I_FIRST = 1.
- ISSUE: C_WE (store) or C_RREQ (fetch/load) high for exactly one cycle; go to WAIT.
- WAIT: C_* held stable; on C_RDY, capture C_DOUT into the owner's DOUT register for reads only; go to RESP.
- RESP: owner's RDY high for one cycle; REQ inputs ignored; go to IDLE.
- Stores leave D_DOUT unchanged. I_DOUT/D_DOUT hold until that port's next read completes.
- C_RDY outside WAIT is ignored.
- Changes to requester inputs after latching are ignored until the next grant.
- Reset mid-transaction aborts it: state goes to IDLE and no RDY pulse is issued. The cache shares RST.
- Reset values: all outputs 0; GNT_D = ~I_FIRST; state IDLE.

## Timing
- REQ seen in IDLE at cycle N. ISSUE strobe at N+1. WAIT from N+2. C_RDY at cycle M ≥ N+2. DOUT valid and RDY pulse at M+1. IDLE at M+2.
- Minimum request-to-RDY latency is 3 cycles (cache answering at N+2).
- Back-to-back: at most one transaction per 4 cycles. A REQ still high at M+2 is re-arbitrated as a new request.
- Requester drops REQ, or presents its next request, in the cycle after its RDY pulse.
- Every C_* output is driven directly from a register, with no combinational path from REQ inputs.

## Configuration
- ARB_FIXED_PRIO_EN defined: D-port always wins simultaneous requests, and I_FIRST is ignored. The I-port can starve while D_REQ is held continuously.
- Not defined: round-robin as above. Continuous dual requests alternate I, D, I, D…

## Test plan
- Single fetch: I_REQ, I_ADDR = 0x100, cache returns 0xDEADBEEF with C_RDY at N+5 -> one C_RREQ pulse at N+1 with C_ADDR = 0x100, C_LIM = 3; I_DOUT = 0xDEADBEEF and I_RDY pulse at N+6; D_RDY stays 0.
- Store byte: D_WE = 1, D_ADDR = 0x20, D_DIN = 0xA5, D_LIM = 0 -> C_WE pulse once with C_DIN = 0xA5, C_LIM = 0; D_RDY after C_RDY; D_DOUT unchanged.
- Tie after reset, I_FIRST = 1, both REQ held -> grant order I, D, I, D over 4 transactions. With ARB_FIXED_PRIO_EN: D every time, and I_RDY never pulses.
- Signed halfword load: D_LIM = 1, D_SIGNED = 1 -> C_LIM = 1, C_SIGNED = 1; D_DOUT equals C_DOUT = 0xFFFF8000.
- Spurious C_RDY in IDLE and D_ADDR changed during WAIT -> no RDY pulse; C_ADDR keeps the latched value.
- RST asserted in WAIT -> immediately IDLE with all outputs 0. A later C_RDY produces no RDY, and the next request proceeds normally.
